// File: rtl/fsk_packet_ctrl_if.sv
// Byte delivery channel from the FSK packet sequencer to its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds OUT_READY low to stall; OUT_DATA is held while OUT_VALID=1.
//
// Signals:
//   OUT_DATA   8  payload byte, MSB first on air
//   OUT_VALID  1  OUT_DATA holds an unconsumed byte
//   OUT_READY  1  consumer accepts the byte when OUT_VALID & OUT_READY
interface fsk_packet_ctrl_if;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;

  modport master (output OUT_DATA, output OUT_VALID, input OUT_READY);
  modport slave  (input OUT_DATA, input OUT_VALID, output OUT_READY);
endinterface

// File: rtl/fsk_packet_ctrl.sv
// Packet sequencer for the FSK receive path: sync-word hunt, byte framing, delivery.
// Latency: one CLOCK from the SAMP cycle that completes an event to its visible outputs.
// Backpressure: a byte completing while the previous one is unconsumed aborts the packet.
//
// Ports:
//   CLOCK, RESET        clock, synchronous active-high reset
//   ENABLE              receiver enable; low forces IDLE
//   SAMP, BIT_IN        one-cycle symbol strobe and the symbol decision it qualifies
//   out_if (master)     OUT_DATA / OUT_VALID / OUT_READY byte channel
//   PKT_START/DONE/ABORT one-cycle status pulses
//   STATE               IDLE=0, SEARCH=1, PAYLOAD=2, DONE=3
module fsk_packet_ctrl #(
  parameter int unsigned         SYNC_LEN      = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = 16'h2DD4,
  parameter int unsigned         MAX_ERR       = 1,
  parameter int unsigned         PAYLOAD_BYTES = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               SAMP,
  input  logic               BIT_IN,
  fsk_packet_ctrl_if.master  out_if,
  output logic               PKT_START,
  output logic               PKT_DONE,
  output logic               PKT_ABORT,
  output logic [1:0]         STATE
);

  localparam int unsigned    FW        = $clog2(SYNC_LEN + 1);
  localparam logic [FW-1:0]  FILL_MAX  = FW'(SYNC_LEN);
  localparam logic [7:0]     LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, PAYLOAD = 2'd2, DONE = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [SYNC_LEN-1:0] sr, sr_d;
  logic [FW-1:0]       fill, fill_d;
  logic [7:0]          shift_byte, shift_d;
  logic [2:0]          bitcnt, bitcnt_d;
  logic [7:0]          bytecnt, bytecnt_d;
  logic [7:0]          data_d;
  logic                valid_d, start_d, done_d, abort_d;

  function automatic int unsigned popcnt(input logic [SYNC_LEN-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < SYNC_LEN; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  logic [SYNC_LEN-1:0] sr_shift;
  logic [FW-1:0]       fill_inc;
  logic                match, byte_full, last_byte, overflow;
  logic [7:0]          byte_shift;

  assign sr_shift   = {sr[SYNC_LEN-2:0], BIT_IN};
  assign fill_inc   = (fill == FILL_MAX) ? fill : fill + FW'(1);
  assign match      = (fill_inc == FILL_MAX) && (popcnt(sr_shift ^ SYNC_WORD) <= MAX_ERR);
  assign byte_shift = {shift_byte[6:0], BIT_IN};
  assign byte_full  = (bitcnt == 3'd7);
  assign last_byte  = (bytecnt == LAST_BYTE);
  // An accept in the same cycle frees the slot, so only an unaccepted byte overflows.
  assign overflow   = out_if.OUT_VALID && !out_if.OUT_READY;

  assign STATE = state;

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; ENABLE low wins over any SAMP in the same cycle
  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SEARCH;
        SEARCH:  if (SAMP && match) state_nxt = PAYLOAD;
        PAYLOAD: if (SAMP && byte_full)
                   state_nxt = overflow ? SEARCH : (last_byte ? DONE : PAYLOAD);
        DONE:    if (!out_if.OUT_VALID) state_nxt = SEARCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    sr_d      = sr;
    fill_d    = fill;
    shift_d   = shift_byte;
    bitcnt_d  = bitcnt;
    bytecnt_d = bytecnt;
    data_d    = out_if.OUT_DATA;
    valid_d   = out_if.OUT_VALID && !out_if.OUT_READY;
    start_d   = 1'b0;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    if (!ENABLE) begin
      valid_d = 1'b0;
      abort_d = (state == PAYLOAD);
    end else begin
      case (state)
        IDLE: begin
          sr_d   = '0;
          fill_d = '0;
        end
        SEARCH: if (SAMP) begin
          sr_d   = sr_shift;
          fill_d = fill_inc;
          if (match) begin
            start_d   = 1'b1;
            bitcnt_d  = 3'd0;
            bytecnt_d = 8'd0;
          end
        end
        PAYLOAD: if (SAMP) begin
          if (!byte_full) begin
            shift_d  = byte_shift;
            bitcnt_d = bitcnt + 3'd1;
          end else if (overflow) begin
            // Drop the new byte and the held one; resume hunting from scratch.
            abort_d  = 1'b1;
            valid_d  = 1'b0;
            sr_d     = '0;
            fill_d   = '0;
            bitcnt_d = 3'd0;
          end else begin
            data_d    = byte_shift;
            valid_d   = 1'b1;
            bytecnt_d = bytecnt + 8'd1;
            bitcnt_d  = 3'd0;
            done_d    = last_byte;
          end
        end
        DONE: if (!out_if.OUT_VALID) begin
          sr_d   = '0;
          fill_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sr               <= '0;
      fill             <= '0;
      shift_byte       <= '0;
      bitcnt           <= '0;
      bytecnt          <= '0;
      out_if.OUT_DATA  <= '0;
      out_if.OUT_VALID <= 1'b0;
      PKT_START        <= 1'b0;
      PKT_DONE         <= 1'b0;
      PKT_ABORT        <= 1'b0;
    end else begin
      sr               <= sr_d;
      fill             <= fill_d;
      shift_byte       <= shift_d;
      bitcnt           <= bitcnt_d;
      bytecnt          <= bytecnt_d;
      out_if.OUT_DATA  <= data_d;
      out_if.OUT_VALID <= valid_d;
      PKT_START        <= start_d;
      PKT_DONE         <= done_d;
      PKT_ABORT        <= abort_d;
    end
  end

endmodule
